rv_sync_fifo: RTL and testbench



---
 rtl/rv_fifo_pkg.sv | 13 +
 rtl/rv_fifo_ctrl.sv | 66 ++++++
 rtl/rv_sync_fifo.sv | 61 ++++++
 tb/tb_rv_sync_fifo.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rv_fifo_pkg.sv
// Shared helpers for the ready/valid FIFO: pointer width and depth check.
// No ports; imported by rv_fifo_ctrl and rv_sync_fifo.
package rv_fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/rv_fifo_ctrl.sv
// FIFO pointer/occupancy control: wr_ptr, rd_ptr, count, full/empty, push/pop.
// Ports: clk, reset, in_valid, out_ready -> in_ready, empty, push, wr_idx, rd_idx, count.
// Option: RV_SYNC_FIFO_BYPASS_EN suppresses the write on a pass-through beat.
module rv_fifo_ctrl
  import rv_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       out_ready,
  output logic                       in_ready,
  output logic                       empty,
  output logic                       push,
  output logic [$clog2(DEPTH)-1:0]   wr_idx,
  output logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int IW = PW - 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          byp;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) &&
                 (wr_ptr[IW] != rd_ptr[IW]);

  // Held low during reset so upstream never sees a stale accept.
  assign in_ready = !full && !reset;

`ifdef RV_SYNC_FIFO_BYPASS_EN
  // Empty FIFO with a taker downstream: beat goes straight through.
  assign byp = empty && in_valid && out_ready;
`else
  assign byp = 1'b0;
`endif

  assign push = in_valid && in_ready && !byp;
  assign pop  = !empty && out_ready;

  assign wr_idx = wr_ptr[IW-1:0];
  assign rd_idx = rd_ptr[IW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rv_sync_fifo.sv
// Synchronous ready/valid FIFO: storage array, head mux and control.
// Ports: clk, reset, in_valid/in_data/in_ready, out_valid/out_data/out_ready, count.
// Option: RV_SYNC_FIFO_BYPASS_EN enables zero-latency pass-through when empty.
module rv_sync_fifo
  import rv_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("rv_sync_fifo: DEPTH must be a power of 2 and >= 2");
  end

  localparam int IW = ptr_w(DEPTH) - 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  empty;
  logic                  push;
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;

  rv_fifo_ctrl #(
    .DEPTH(DEPTH)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .in_ready (in_ready),
    .empty    (empty),
    .push     (push),
    .wr_idx   (wr_idx),
    .rd_idx   (rd_idx),
    .count    (count)
  );

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= in_data;
  end

`ifdef RV_SYNC_FIFO_BYPASS_EN
  assign out_valid = (!empty || in_valid) && !reset;
  assign out_data  = empty ? in_data : mem[rd_idx];
`else
  assign out_valid = !empty;
  assign out_data  = mem[rd_idx];
`endif

endmodule

// File: tb/tb_rv_sync_fifo.sv
// Directed scoreboard bench for rv_sync_fifo (DEPTH=4, DATA_WIDTH=8).
// Checks reset, fill/refuse, drain, streaming, stall and mid-run reset.
module tb_rv_sync_fifo;

  localparam int DW = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [2:0]    count;

  logic [DW-1:0] q[$];
  int n_cmp = 0;
  int n_err = 0;

  rv_sync_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive after negedge, check model, advance model at posedge.
  task automatic cyc(input logic iv, input logic [DW-1:0] d,
                     input logic ordy);
    logic exp_ov, exp_ir, do_push, do_pop, thru;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_ir = (q.size() < DP);
    thru   = 1'b0;
`ifdef RV_SYNC_FIFO_BYPASS_EN
    thru   = (q.size() == 0) && iv && ordy;
    exp_ov = (q.size() != 0) || iv;
`else
    exp_ov = (q.size() != 0);
`endif
    chk("count", 32'(count), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (q.size() != 0)
      chk("out_data", 32'(out_data), 32'(q[0]));
    else if (thru)
      chk("bypass_data", 32'(out_data), 32'(d));
    do_push = iv && exp_ir && !thru;
    do_pop  = (q.size() != 0) && ordy;
    @(posedge clk);
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(d);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    repeat (10) cyc(1'b0, 8'h00, 1'b1);

    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    cyc(1'b1, 8'h44, 1'b0);
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'h66, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    repeat (4) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 64; i++) cyc(1'b1, 8'(i), 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    cyc(1'b1, 8'hC1, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0);
    repeat (5) cyc(1'b0, 8'h00, 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b1);

    cyc(1'b1, 8'hD1, 1'b0);
    cyc(1'b1, 8'hD2, 1'b0);
    cyc(1'b1, 8'hD3, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h5A, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
